// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, fetches 8-bit instructions
// over a req/ack handshake and holds each one for decode until it is consumed.
module instr_fetch #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              jump,
    output logic [7:0]        instr,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [7:0]        instr_q,   instr_d;
    logic [ADDR_W-1:0] pc_out_q,  pc_out_d;
    logic              valid_q,   valid_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic              in_fetch;
    logic              in_hold;
    logic              capture;
    logic              consume;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;

    assign in_fetch = (state_q == ST_FETCH);
    assign in_hold  = (state_q == ST_HOLD);
    assign capture  = in_fetch & imem_ack;
    assign consume  = in_hold & valid_q & ~stall;

    // Jumps stay inside the current 32-instruction page of the held instruction.
    assign seq_pc  = pc_out_q + PC_ONE;
    assign jump_pc = {pc_out_q[ADDR_W-1:5], instr_q[4:0]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (capture) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    retired_d = retired_q + CNT_ONE;
                    valid_d   = 1'b0;
                    pc_d      = jump ? jump_pc : seq_pc;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_INIT;
            instr_q   <= 8'h00;
            pc_out_q  <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = in_fetch;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[7:5];
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the opcode decoder. It holds the program counter and fetches 8-bit instructions from instruction memory over a req/ack handshake. It presents the held instruction and its 3-bit opcode field to decode. It redirects the PC when decode raises jump for the instruction currently presented.

Parameters:
ADDR_W, 8, program counter and instruction memory address width (must be >= 6)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request; high throughout state FETCH
imem_addr  output  ADDR_W  fetch address; equals pc, stable while imem_req is high
imem_rdata  input  8  instruction data; valid in the cycle imem_ack is high
imem_ack  input  1  memory completion; sampled only while imem_req is high
stall  input  1  decode/execute cannot accept the presented instruction this cycle
jump  input  1  decode's jump decision for the presented instruction
instr  output  8  held instruction
opcode  output  3  instr[7:5], fed to decode
pc_out  output  ADDR_W  address of the held instruction
instr_valid  output  1  instr/opcode/pc_out are meaningful
retired  output  CNT_W  count of consumed instructions, wraps at 2^CNT_W

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release). The following hold immediately:
  - state = IDLE, pc = RESET_PC
  - instr = 0, pc_out = 0, instr_valid = 0, imem_req = 0, retired = 0
- States:
  - IDLE -> FETCH unconditionally on the first clock after reset release.
  - FETCH: imem_req = 1 and imem_addr = pc. On imem_ack, capture imem_rdata into instr and pc into pc_out, then go to HOLD. With no ack, stay (any wait length).
  - HOLD: instr_valid = 1 and imem_req = 0. Consume is instr_valid & !stall.
    - On consume: retired += 1, go to FETCH.
    - pc <= jump ? {pc_out[ADDR_W-1:5], instr[4:0]} : pc_out + 1.
    - With stall high, everything holds; jump is ignored.
- instr_valid is registered. It deasserts in the cycle after consume and stays low until the next ack is captured.
- opcode is a pure function of the instr register (instr[7:5]); no extra latency.
- Throughput with imem_ack tied high is one instruction per 2 cycles:
  - cycle n: FETCH with ack
  - cycle n+1: HOLD, consumed
  - cycle n+2: FETCH for the next address
- Latency from imem_ack to instr_valid is 1 cycle.
- PC arithmetic: pc_out + 1 is modulo 2^ADDR_W, so 0xFF wraps to 0x00 with ADDR_W=8. The jump target keeps the upper ADDR_W-5 bits of pc_out (page-relative, 32-instruction pages).
- jump and stall are ignored outside HOLD. imem_ack is ignored outside FETCH.
- Reset mid-fetch: an outstanding request is abandoned and a late ack after release is ignored. IDLE guarantees one req-low cycle before the first post-reset request.
- Reset mid-HOLD: the instruction is discarded without being counted.

Test Plan:
- Reset/first fetch, RESET_PC=0, ack tied high, rdata=0x83 at addr 0:
  - while rst_n=0: imem_req=0, instr_valid=0, retired=0
  - after release: IDLE 1 cycle, then req with addr 0x00
  - next cycle: instr=0x83, opcode=3'b100, pc_out=0, instr_valid=1
- Sequential stream, stall=0, jump=0, memory addr k returns k: addresses 0,1,2,3 requested on alternating cycles; instr_valid toggles 1/0; retired=4 after 4 consumes.
- Stall hold: stall=1 for 5 cycles in HOLD -> instr, pc_out and retired stay constant, imem_req stays 0. On stall=0, consume occurs in that cycle and the next req is to pc_out+1.
- Jump: pc_out=0x25, instr=0x4A, jump=1 at consume -> next imem_addr=0x2A (upper bits 001 of 0x25 kept, low 5 bits 01010). The same jump with stall=1 has no effect.
- Variable memory latency and wrap: ack delayed 3 cycles -> imem_addr stays stable and instr_valid stays 0 until ack+1. At pc_out=0xFF with no jump -> next address 0x00.
- Reset during FETCH with ack arriving in the cycle after release: ack is ignored, first post-reset request goes to RESET_PC, retired=0.
